bmc_soft_pipe: RTL and testbench

//  Parametrised, pipelined soft-decision branch metric unit for the Viterbi decoder.
//  - Per received symbol of CODE_N soft bits, computes the distance to all 2^CODE_N codewords.
//  - Sits between the channel/depuncture front end and the add-compare-select array.
//  - Uses a 2-stage registered pipeline with valid/ready backpressure and frame (last) tracking.

---
 rtl/vit_pkg.sv | 20 ++
 rtl/bmc_bit_dist.sv | 33 +++
 rtl/bmc_soft_pipe.sv | 115 +++++++++++
 tb/tb_bmc_soft_pipe.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vit_pkg.sv
// vit_pkg: shared constants, types and helpers for the Viterbi decoder datapath.
// Optional build macro used by the branch metric blocks: BMC_ERASURE_EN.
package vit_pkg;

   localparam int CODE_N_DEF = 2;
   localparam int SOFT_W_DEF = 3;

   typedef logic [SOFT_W_DEF-1:0] soft_t;

   // Metric width: one soft value plus enough headroom for CODE_N of them.
   function automatic int bm_width(input int code_n, input int soft_w);
      return soft_w + $clog2(code_n);
   endfunction

   // Bit k of codeword index c selects which distance bit k contributes.
   function automatic logic cw_bit(input int c, input int k);
      return logic'((c >> k) & 1);
   endfunction

endpackage

// File: rtl/bmc_bit_dist.sv
// bmc_bit_dist: distance of one soft bit to a hard '0' and to a hard '1'.
// With BMC_ERASURE_EN defined an erase input zeroes both distances so the
// bit carries no weight in any codeword metric.
module bmc_bit_dist #(
   parameter int SOFT_W = 3
)(
   input  logic [SOFT_W-1:0] rx,
`ifdef BMC_ERASURE_EN
   input  logic              erase,
`endif
   output logic [SOFT_W-1:0] d0,
   output logic [SOFT_W-1:0] d1
);

   localparam logic [SOFT_W-1:0] MAX = '1;

   // Per-bit distances, gated by erasure when that feature is built in.
   always_comb begin
`ifdef BMC_ERASURE_EN
      if (erase) begin
         d0 = '0;
         d1 = '0;
      end else begin
         d0 = rx;
         d1 = MAX - rx;
      end
`else
      d0 = rx;
      d1 = MAX - rx;
`endif
   end

endmodule

// File: rtl/bmc_soft_pipe.sv
// bmc_soft_pipe: two-stage soft-decision branch metric unit with valid/ready
// backpressure, frame tracking (bm_last) and a saturating per-frame symbol index.
// Optional build macro: BMC_ERASURE_EN adds rx_erase for depunctured bits.
module bmc_soft_pipe
   import vit_pkg::*;
#(
   parameter  int CODE_N = CODE_N_DEF,
   parameter  int SOFT_W = SOFT_W_DEF,
   parameter  int CNT_W  = 16,
   localparam int NUM_CW = 2**CODE_N,
   localparam int BM_W   = bm_width(CODE_N, SOFT_W)
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   input  logic [CODE_N*SOFT_W-1:0] rx_sym,
   input  logic                     rx_last,
`ifdef BMC_ERASURE_EN
   input  logic [CODE_N-1:0]        rx_erase,
`endif
   output logic                     bm_valid,
   input  logic                     bm_ready,
   output logic [NUM_CW*BM_W-1:0]   bm_out,
   output logic                     bm_last,
   output logic [CNT_W-1:0]         sym_cnt
);

   logic                    s1_valid;
   logic                    s1_last;
   logic                    s2_valid;
   logic                    adv1;
   logic                    adv2;
   logic [SOFT_W-1:0]       d0_w  [CODE_N];
   logic [SOFT_W-1:0]       d1_w  [CODE_N];
   logic [SOFT_W-1:0]       s1_d0 [CODE_N];
   logic [SOFT_W-1:0]       s1_d1 [CODE_N];
   logic [NUM_CW*BM_W-1:0]  sum;

   // A stage may load when it is empty or the stage after it is moving.
   assign adv2     = !s2_valid || bm_ready;
   assign adv1     = !s1_valid || adv2;
   assign rx_ready = adv1;
   assign bm_valid = s2_valid;

   for (genvar k = 0; k < CODE_N; k++) begin : g_bit
      bmc_bit_dist #(.SOFT_W(SOFT_W)) u_dist (
         .rx    (rx_sym[k*SOFT_W +: SOFT_W]),
`ifdef BMC_ERASURE_EN
         .erase (rx_erase[k]),
`endif
         .d0    (d0_w[k]),
         .d1    (d1_w[k])
      );
   end

   // Stage 1: capture per-bit distances and the frame marker.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         for (int k = 0; k < CODE_N; k++) begin
            s1_d0[k] <= '0;
            s1_d1[k] <= '0;
         end
      end else if (adv1) begin
         s1_valid <= rx_valid;
         if (rx_valid) begin
            s1_last <= rx_last;
            s1_d0   <= d0_w;
            s1_d1   <= d1_w;
         end
      end
   end

   // Codeword metrics: each bit adds its distance to the hard value the codeword expects.
   always_comb begin
      sum = '0;
      for (int c = 0; c < NUM_CW; c++) begin
         for (int k = 0; k < CODE_N; k++) begin
            sum[c*BM_W +: BM_W] = sum[c*BM_W +: BM_W]
                                + BM_W'(cw_bit(c, k) ? s1_d1[k] : s1_d0[k]);
         end
      end
   end

   // Stage 2: register metrics and frame marker; outputs hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         bm_out   <= '0;
         bm_last  <= 1'b0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            bm_out  <= sum;
            bm_last <= s1_last;
         end
      end
   end

   // Symbol index of the presented output: advances on each output transfer,
   // restarts after the frame's last symbol, and sticks at all-ones on long frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         sym_cnt <= '0;
      end else if (s2_valid && bm_ready) begin
         if (bm_last)
            sym_cnt <= '0;
         else if (sym_cnt != '1)
            sym_cnt <= sym_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// tb_bmc_soft_pipe: scoreboard bench for bmc_soft_pipe. A default-parameter
// instance covers metrics, backpressure, framing and reset; a hard-decision
// instance (SOFT_W=1, CNT_W=4) covers Hamming metrics and counter saturation.
module tb_bmc_soft_pipe;

   typedef struct packed {
      logic [15:0] bm;
      logic        last;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid, rx_ready, rx_last;
   logic [5:0]  rx_sym;
   logic [1:0]  rx_erase;
   logic        bm_valid, bm_ready, bm_last;
   logic [15:0] bm_out;
   logic [15:0] sym_cnt;

   logic        rx_valid_h, rx_ready_h, rx_last_h;
   logic [1:0]  rx_sym_h;
   logic        bm_valid_h, bm_ready_h, bm_last_h;
   logic [7:0]  bm_out_h;
   logic [3:0]  sym_cnt_h;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb_q[$];
   exp_t sb_h[$];
   int   pos_m  = 0;
   int   pos_h  = 0;
   bit   saw_full = 0;
   bit   done;

   always #5 clk = ~clk;

   bmc_soft_pipe dut (
      .clk      (clk),
      .rst      (rst),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .rx_sym   (rx_sym),
      .rx_last  (rx_last),
`ifdef BMC_ERASURE_EN
      .rx_erase (rx_erase),
`endif
      .bm_valid (bm_valid),
      .bm_ready (bm_ready),
      .bm_out   (bm_out),
      .bm_last  (bm_last),
      .sym_cnt  (sym_cnt)
   );

   bmc_soft_pipe #(.CODE_N(2), .SOFT_W(1), .CNT_W(4)) dut_hd (
      .clk      (clk),
      .rst      (rst),
      .rx_valid (rx_valid_h),
      .rx_ready (rx_ready_h),
      .rx_sym   (rx_sym_h),
      .rx_last  (rx_last_h),
`ifdef BMC_ERASURE_EN
      .rx_erase (2'b00),
`endif
      .bm_valid (bm_valid_h),
      .bm_ready (bm_ready_h),
      .bm_out   (bm_out_h),
      .bm_last  (bm_last_h),
      .sym_cnt  (sym_cnt_h)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference metrics for CODE_N=2: field c is BM_W=sw+1 bits wide.
   function automatic logic [15:0] calc_bm(input int sym, input int erase, input int sw);
      int mx = (1 << sw) - 1;
      int bw = sw + 1;
      logic [15:0] r = '0;
      for (int c = 0; c < 4; c++) begin
         int s = 0;
         for (int k = 0; k < 2; k++) begin
            int b = (sym >> (k*sw)) & mx;
            if (((erase >> k) & 1) == 0)
               s += ((c >> k) & 1) != 0 ? (mx - b) : b;
         end
         r = r | 16'(s << (c*bw));
      end
      return r;
   endfunction

   task automatic send(input logic [5:0] sym, input logic last, input logic [1:0] er);
      int   w = 0;
      int   e;
      exp_t x;
      @(negedge clk);
      rx_valid = 1'b1; rx_sym = sym; rx_last = last; rx_erase = er;
      #1;
      while (!rx_ready) begin
         if (++w > 200) begin
            check("send_timeout", 0, 1);
            break;
         end
         @(negedge clk); #1;
      end
`ifdef BMC_ERASURE_EN
      e = int'(er);
`else
      e = 0;
`endif
      x.bm = calc_bm(int'(sym), e, 3);
      x.last = last;
      x.cnt = 16'(pos_m);
      sb_q.push_back(x);
      if (last) pos_m = 0;
      else if (pos_m < 65535) pos_m++;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_h(input logic [1:0] sym, input logic last);
      int   w = 0;
      exp_t x;
      @(negedge clk);
      rx_valid_h = 1'b1; rx_sym_h = sym; rx_last_h = last;
      #1;
      while (!rx_ready_h) begin
         if (++w > 200) begin
            check("send_h_timeout", 0, 1);
            break;
         end
         @(negedge clk); #1;
      end
      x.bm = calc_bm(int'(sym), 0, 1);
      x.last = last;
      x.cnt = 16'(pos_h);
      sb_h.push_back(x);
      if (last) pos_h = 0;
      else if (pos_h < 15) pos_h++;
      @(posedge clk); #1;
      rx_valid_h = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb_q.size() != 0 || sb_h.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_main", sb_q.size(), 0);
      check("drain_hd", sb_h.size(), 0);
   endtask

   // Main monitor: scoreboard pops on output transfers, stability under stall.
   logic [15:0] held_bm, held_cnt;
   logic        held_last;
   bit          was_stall = 0;
   always begin
      exp_t e;
      @(negedge clk); #2;
      if (rst) begin
         was_stall = 0;
      end else begin
         if (was_stall) begin
            check("stall_bm", bm_out, held_bm);
            check("stall_last", bm_last, held_last);
            check("stall_cnt", sym_cnt, held_cnt);
         end
         if (bm_valid && !rx_ready) saw_full = 1;
         if (bm_valid && bm_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("bm_out", bm_out, e.bm);
               check("bm_last", bm_last, e.last);
               check("sym_cnt", sym_cnt, e.cnt);
            end
         end
         was_stall = bm_valid && !bm_ready;
         held_bm = bm_out; held_last = bm_last; held_cnt = sym_cnt;
      end
   end

   // Hard-decision monitor.
   always begin
      exp_t e;
      @(negedge clk); #2;
      if (!rst && bm_valid_h && bm_ready_h) begin
         if (sb_h.size() == 0) begin
            check("hd_unexpected_out", 1, 0);
         end else begin
            e = sb_h.pop_front();
            check("hd_bm_out", bm_out_h, e.bm[7:0]);
            check("hd_bm_last", bm_last_h, e.last);
            check("hd_sym_cnt", sym_cnt_h, e.cnt[3:0]);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      rx_valid = 0; rx_sym = '0; rx_last = 0; rx_erase = '0; bm_ready = 1'b1;
      rx_valid_h = 0; rx_sym_h = '0; rx_last_h = 0; bm_ready_h = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0; #1;
      check("rst_bm_valid", bm_valid, 0);
      check("rst_bm_out", bm_out, 0);
      check("rst_bm_last", bm_last, 0);
      check("rst_sym_cnt", sym_cnt, 0);
      check("rst_rx_ready", rx_ready, 1);

      // Two-cycle latency and the {b1=7,b0=0} metrics.
      send({3'd7, 3'd0}, 1'b1, 2'b00);
      @(negedge clk); #2;
      check("lat_not_yet", bm_valid, 0);
      @(negedge clk); #2;
      check("lat_valid", bm_valid, 1);
      check("t1_bm", bm_out, 16'h70E7);

      // Erasure of bit 0 on {b1=7,b0=3}.
      send({3'd7, 3'd3}, 1'b1, 2'b01);
      @(negedge clk);
      @(negedge clk); #2;
`ifdef BMC_ERASURE_EN
      check("erase_bm", bm_out, 16'h0077);
`else
      check("noerase_bm", bm_out, 16'h43BA);
`endif
      drain();

      // Eight-symbol stream with bm_ready low on cycles 3..6.
      saw_full = 0;
      fork
         for (int i = 0; i < 8; i++)
            send(6'($urandom_range(0, 63)), i == 7, 2'b00);
         for (int cyc = 0; cyc < 13; cyc++) begin
            @(negedge clk);
            bm_ready = !(cyc >= 3 && cyc <= 6);
         end
      join
      bm_ready = 1'b1;
      drain();
      check("rx_ready_dropped", saw_full, 1);

      // Frame of 5 followed at once by a frame of 3.
      for (int i = 0; i < 5; i++) send(6'($urandom_range(0, 63)), i == 4, 2'b00);
      for (int i = 0; i < 3; i++) send(6'($urandom_range(0, 63)), i == 2, 2'b00);
      drain();

      // Random backpressure over two frames.
      done = 0;
      fork
         begin
            for (int i = 0; i < 20; i++)
               send(6'($urandom_range(0, 63)), i == 9 || i == 19, 2'($urandom_range(0, 3)));
            done = 1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               bm_ready = $urandom_range(0, 3) != 0;
            end
            bm_ready = 1'b1;
         end
      join
      drain();

      // Mid-frame reset with two symbols in flight.
      for (int i = 0; i < 3; i++) send(6'($urandom_range(0, 63)), 1'b0, 2'b00);
      drain();
      @(negedge clk); bm_ready = 1'b0;
      send(6'd5, 1'b0, 2'b00);
      send(6'd9, 1'b0, 2'b00);
      @(negedge clk);
      rst = 1'b1;
      sb_q.delete();
      pos_m = 0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mrst_bm_valid", bm_valid, 0);
      check("mrst_sym_cnt", sym_cnt, 0);
      check("mrst_rx_ready", rx_ready, 1);
      check("mrst_bm_out", bm_out, 0);
      bm_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check("mrst_no_stale", bm_valid, 0);
      for (int i = 0; i < 2; i++) send(6'($urandom_range(0, 63)), i == 1, 2'b00);
      drain();

      // Hard-decision: rx_sym=2'b10 gives {1,2,0,1}.
      send_h(2'b10, 1'b0);
      @(negedge clk);
      @(negedge clk); #2;
      check("hd_hamming", bm_out_h, 8'h49);
      for (int i = 0; i < 4; i++) send_h(2'(i), 1'b0);
      // Long frame forces the 4-bit index to saturate at 15.
      for (int i = 0; i < 18; i++) send_h(2'($urandom_range(0, 3)), i == 17);
      send_h(2'b11, 1'b1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
